score_text_rom: RTL and testbench



---
 rtl/score_text_rom_pkg.sv | 48 ++++
 rtl/score_text_rom_if.sv | 28 ++
 rtl/score_text_rom_bin2bcd_seq.sv | 81 ++++++++
 rtl/score_text_rom.sv | 180 ++++++++++++++++++
 tb/tb_score_text_rom.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/score_text_rom_pkg.sv
// -----------------------------------------------------------------------------
// score_text_pkg
// Shared constants and types for the score panel text source:
//   - ASCII codes and the two row labels
//   - screen layout (first digit column, row numbers)
//   - converter FSM state type
//   - helpers for BCD register sizing and label lookup
// -----------------------------------------------------------------------------
package score_text_pkg;

   localparam logic [7:0]  ASCII_SPACE = 8'h20;
   localparam logic [7:0]  ASCII_ZERO  = 8'h30;
   localparam logic [7:0]  ASCII_NINE  = 8'h39;

   // Seven characters each; the leftmost character sits in the top byte.
   localparam logic [55:0] LABEL_SCORE = "SCORE: ";
   localparam logic [55:0] LABEL_HI    = "HIGH:  ";

   localparam int DIGIT_COL = 7;
   localparam int ROW_SCORE = 0;
   localparam int ROW_HI    = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_WRITE
   } conv_state_e;

   // Nibbles the double-dabble register needs: enough for every decimal
   // digit a VALUE_W-bit number can have, and never fewer than displayed.
   function automatic int bcd_nibbles(input int value_w, input int digits);
      int need;
      need = (value_w * 302 + 999) / 1000 + 1;
      return (digits > need) ? digits : need;
   endfunction

   // Character 'col' (0..6) of a seven-character label.
   function automatic logic [7:0] label_char(input logic [55:0] label,
                                             input logic [2:0]  col);
      logic [7:0] ch;
      ch = ASCII_SPACE;
      for (int i = 0; i < 7; i++) begin
         if (col == 3'(i)) ch = label[8*(6-i) +: 8];
      end
      return ch;
   endfunction

endpackage

// File: rtl/score_text_rom_if.sv
// -----------------------------------------------------------------------------
// score_text_rom_if
// Bus between the score panel text source and its users.
//   char_xy    : cell address, [7:4] row, [3:0] column   (master -> slave)
//   score_in   : current score, binary                   (master -> slave)
//   hiscore_in : high score, binary                      (master -> slave)
//   char_code  : ASCII code of the addressed cell        (slave -> master)
//   bcd_valid  : displayed values equal current inputs   (slave -> master)
// -----------------------------------------------------------------------------
interface score_text_rom_if #(
   parameter int VALUE_W = 16
);
   logic [7:0]         char_xy;
   logic [VALUE_W-1:0] score_in;
   logic [VALUE_W-1:0] hiscore_in;
   logic [7:0]         char_code;
   logic               bcd_valid;

   modport master (
      output char_xy, score_in, hiscore_in,
      input  char_code, bcd_valid
   );

   modport slave (
      input  char_xy, score_in, hiscore_in,
      output char_code, bcd_valid
   );
endinterface

// File: rtl/score_text_rom_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_start    : load i_value and begin a VALUE_W-step conversion
//   i_value    : binary value to convert
//   o_busy     : conversion steps in progress
//   o_done     : the final step happens on the coming edge; o_bcd/o_sat
//                are valid from the cycle after that edge until next start
//   o_bcd      : low DIGITS BCD digits of the result
//   o_sat      : result does not fit in DIGITS decimal digits
// -----------------------------------------------------------------------------
module bin2bcd_seq
   import score_text_pkg::*;
#(
   parameter int VALUE_W = 16,
   parameter int DIGITS  = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic [VALUE_W-1:0]  i_value,
   output logic                o_busy,
   output logic                o_done,
   output logic [4*DIGITS-1:0] o_bcd,
   output logic                o_sat
);

   localparam int BCD_N = bcd_nibbles(VALUE_W, DIGITS);
   localparam int BCD_W = 4 * BCD_N;
   localparam int CNT_W = $clog2(VALUE_W);

   logic [VALUE_W-1:0] r_bin;
   logic [BCD_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic [BCD_W-1:0]   w_adj;

   // Add-3 correction on every nibble of 5 or more, ahead of the shift.
   always_comb begin
      // NOTE: default first so every path assigns w_adj and no latch forms.
      w_adj = r_bcd;
      for (int i = 0; i < BCD_N; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_bin  <= i_value;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_bcd <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
         r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == CNT_W'(VALUE_W - 1)) r_busy <= 1'b0;
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_busy && (r_cnt == CNT_W'(VALUE_W - 1));
   assign o_bcd  = r_bcd[4*DIGITS-1:0];

   // Any nonzero digit above the displayed ones means the value overflows.
   generate
      if (BCD_N > DIGITS) begin : g_sat
         assign o_sat = |r_bcd[BCD_W-1:4*DIGITS];
      end else begin : g_nosat
         assign o_sat = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/score_text_rom.sv
// -----------------------------------------------------------------------------
// score_text_rom
// Text source for the score panel. Converts score and high score to decimal
// through one shared bin2bcd_seq and serves one ASCII code per cell.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : score_text_rom_if slave
//                char_xy in, score_in in, hiscore_in in,
//                char_code out (registered, 1-cycle latency),
//                bcd_valid out (registered)
// Row 0: "SCORE: " + score digits, row 1: "HIGH:  " + high-score digits,
// everything else is a space. Leading zeros optionally blanked; values
// above 10^DIGITS-1 are shown as all nines.
// -----------------------------------------------------------------------------
module score_text_rom
   import score_text_pkg::*;
#(
   parameter int VALUE_W  = 16,
   parameter int DIGITS   = 5,
   parameter int BLANK_LZ = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   score_text_rom_if.slave  bus
);

   conv_state_e          r_state;
   conv_state_e          w_state_next;
   logic                 r_sel;            // 0 = score channel, 1 = high score
   logic [VALUE_W-1:0]   r_snap0;
   logic [VALUE_W-1:0]   r_snap1;
   logic [4*DIGITS-1:0]  r_dig0;
   logic [4*DIGITS-1:0]  r_dig1;
   logic [7:0]           r_char_code;
   logic                 r_bcd_valid;

   logic                 w_score_diff;
   logic                 w_hi_diff;
   logic                 w_load_score;
   logic                 w_load_hi;
   logic                 w_write;
   logic                 w_start;
   logic [VALUE_W-1:0]   w_conv_value;
   logic                 w_conv_busy;
   logic                 w_conv_done;
   logic                 w_conv_sat;
   logic [4*DIGITS-1:0]  w_conv_bcd;
   logic [4*DIGITS-1:0]  w_new_digits;

   logic [3:0]           w_row;
   logic [3:0]           w_col;
   logic [4*DIGITS-1:0]  w_digs;
   logic [DIGITS-1:0]    w_lz;
   logic [7:0]           w_char;

   assign w_score_diff = (bus.score_in   != r_snap0);
   assign w_hi_diff    = (bus.hiscore_in != r_snap1);

   // ---------------- converter arbitration FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_load_score = 1'b0;
      w_load_hi    = 1'b0;
      w_write      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            // Score wins when both channels are stale.
            if (w_score_diff) begin
               w_load_score = 1'b1;
               w_state_next = ST_SHIFT;
            end else if (w_hi_diff) begin
               w_load_hi    = 1'b1;
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_conv_done)       w_state_next = ST_WRITE;
            else if (!w_conv_busy) w_state_next = ST_IDLE;
         end
         ST_WRITE: begin
            w_write      = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_start      = w_load_score | w_load_hi;
   assign w_conv_value = w_load_hi ? bus.hiscore_in : bus.score_in;

   bin2bcd_seq #(
      .VALUE_W (VALUE_W),
      .DIGITS  (DIGITS)
   ) u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start),
      .i_value (w_conv_value),
      .o_busy  (w_conv_busy),
      .o_done  (w_conv_done),
      .o_bcd   (w_conv_bcd),
      .o_sat   (w_conv_sat)
   );

   assign w_new_digits = w_conv_sat ? {DIGITS{4'h9}} : w_conv_bcd;

   // ---------------- snapshots, digit registers, outputs ----------------
   // NOTE: digit registers are reset too, so the panel shows 0 straight
   // out of reset instead of whatever the flops powered up with.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel       <= 1'b0;
         r_snap0     <= '0;
         r_snap1     <= '0;
         r_dig0      <= '0;
         r_dig1      <= '0;
         r_char_code <= ASCII_SPACE;
         r_bcd_valid <= 1'b0;
      end else begin
         if (w_load_score) begin
            r_snap0 <= bus.score_in;
            r_sel   <= 1'b0;
         end else if (w_load_hi) begin
            r_snap1 <= bus.hiscore_in;
            r_sel   <= 1'b1;
         end
         // Whole channel in one edge: the display never sees a half update.
         if (w_write) begin
            if (r_sel) r_dig1 <= w_new_digits;
            else       r_dig0 <= w_new_digits;
         end
         r_bcd_valid <= (r_state == ST_IDLE) && !w_score_diff && !w_hi_diff;
         r_char_code <= w_char;
      end
   end

   assign bus.char_code = r_char_code;
   assign bus.bcd_valid = r_bcd_valid;

   // ---------------- text lookup ----------------
   assign w_row  = bus.char_xy[7:4];
   assign w_col  = bus.char_xy[3:0];
   assign w_digs = (w_row == 4'(ROW_HI)) ? r_dig1 : r_dig0;

   // w_lz[k] (k = 0 is the MSD): digit k and all digits left of it are zero.
   always_comb begin : lz_scan
      logic run;
      run  = 1'b1;
      w_lz = '0;
      for (int k = 0; k < DIGITS; k++) begin
         run     = run && (w_digs[4*(DIGITS-1-k) +: 4] == 4'd0);
         w_lz[k] = run;
      end
   end

   always_comb begin
      w_char = ASCII_SPACE;
      if (w_row == 4'(ROW_SCORE) || w_row == 4'(ROW_HI)) begin
         if (w_col < 4'(DIGIT_COL)) begin
            w_char = label_char((w_row == 4'(ROW_HI)) ? LABEL_HI : LABEL_SCORE,
                                w_col[2:0]);
         end else begin
            for (int k = 0; k < DIGITS; k++) begin
               if (w_col == 4'(DIGIT_COL + k)) begin
                  // The least-significant digit is always drawn.
                  if (BLANK_LZ != 0 && w_lz[k] && k != DIGITS - 1)
                     w_char = ASCII_SPACE;
                  else
                     w_char = ASCII_ZERO + {4'd0, w_digs[4*(DIGITS-1-k) +: 4]};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_score_text_rom.sv
// -----------------------------------------------------------------------------
// tb_score_text_rom
// Three builds side by side on the same inputs:
//   dut    : VALUE_W=16, DIGITS=5, BLANK_LZ=1
//   dut_nz : VALUE_W=16, DIGITS=5, BLANK_LZ=0
//   dut_d4 : VALUE_W=16, DIGITS=4, BLANK_LZ=1
// -----------------------------------------------------------------------------
module tb_score_text_rom;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   score_text_rom_if #(.VALUE_W(16)) bus    ();
   score_text_rom_if #(.VALUE_W(16)) bus_nz ();
   score_text_rom_if #(.VALUE_W(16)) bus_d4 ();

   assign bus_nz.char_xy    = bus.char_xy;
   assign bus_nz.score_in   = bus.score_in;
   assign bus_nz.hiscore_in = bus.hiscore_in;
   assign bus_d4.char_xy    = bus.char_xy;
   assign bus_d4.score_in   = bus.score_in;
   assign bus_d4.hiscore_in = bus.hiscore_in;

   score_text_rom #(.VALUE_W(16), .DIGITS(5), .BLANK_LZ(1)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus));
   score_text_rom #(.VALUE_W(16), .DIGITS(5), .BLANK_LZ(0)) dut_nz (
      .clk (clk), .rst_n (rst_n), .bus (bus_nz));
   score_text_rom #(.VALUE_W(16), .DIGITS(4), .BLANK_LZ(1)) dut_d4 (
      .clk (clk), .rst_n (rst_n), .bus (bus_d4));

   typedef struct {
      logic [7:0] xy;
      logic [7:0] e_main;
      logic [7:0] e_nz;
      logic [7:0] e_d4;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference text: decimal digits by division, independent of the RTL.
   function automatic logic [7:0] model_char(input int row, input int col,
                                             input int unsigned val,
                                             input int digits, input bit blank);
      string       lbl;
      int unsigned lim, place, d;
      if (row > 1) return 8'h20;
      if (col < 7) begin
         if (row == 0) lbl = "SCORE: ";
         else          lbl = "HIGH:  ";
         return lbl[col];
      end
      if (col >= 7 + digits) return 8'h20;
      lim = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      if (val >= lim) return 8'h39;
      place = 1;
      for (int i = 0; i < digits - 1 - (col - 7); i++) place = place * 10;
      if (blank && col != 7 + digits - 1 && val < place) return 8'h20;
      d = (val / place) % 10;
      return 8'h30 + 8'(d);
   endfunction

   // Drive an address, queue the expectation, compare one edge later.
   task automatic read_cell(input logic [7:0] xy, input logic [7:0] e_main,
                            input logic [7:0] e_nz, input logic [7:0] e_d4,
                            input string tag);
      vec_t e;
      bus.char_xy = xy;
      e.xy = xy; e.e_main = e_main; e.e_nz = e_nz; e.e_d4 = e_d4;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check($sformatf("%s xy=%02h main", tag, e.xy), bus.char_code,    e.e_main);
      check($sformatf("%s xy=%02h nz",   tag, e.xy), bus_nz.char_code, e.e_nz);
      check($sformatf("%s xy=%02h d4",   tag, e.xy), bus_d4.char_code, e.e_d4);
   endtask

   task automatic check_rows(input int unsigned sv, input int unsigned hv,
                             input string tag);
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 16; c++) begin
            int unsigned v;
            v = (r == 0) ? sv : hv;
            read_cell({4'(r), 4'(c)}, model_char(r, c, v, 5, 1'b1),
                      model_char(r, c, v, 5, 1'b0), model_char(r, c, v, 4, 1'b1), tag);
         end
      end
      read_cell(8'h27, 8'h20, 8'h20, 8'h20, tag);
      read_cell(8'hF3, 8'h20, 8'h20, 8'h20, tag);
   endtask

   // Wait (bounded) for bcd_valid after an input change.
   task automatic wait_valid(input string tag);
      int n;
      tick();
      n = 0;
      while (!bus.bcd_valid && n < 100) begin
         tick();
         n++;
      end
      check({"wait_valid ", tag}, bus.bcd_valid, 1);
   endtask

   initial begin
      logic [7:0] lbl [2][7];
      lbl[0] = '{8'h53, 8'h43, 8'h4F, 8'h52, 8'h45, 8'h3A, 8'h20};
      lbl[1] = '{8'h48, 8'h49, 8'h47, 8'h48, 8'h3A, 8'h20, 8'h20};
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 7; c++)
            vecs.push_back('{{4'(r), 4'(c)}, lbl[r][c], lbl[r][c], lbl[r][c]});
         for (int c = 7; c < 12; c++)
            vecs.push_back('{{4'(r), 4'(c)}, (c == 11) ? 8'h30 : 8'h20, 8'h30,
                             (c == 10) ? 8'h30 : 8'h20});
      end
      vecs.push_back('{8'h20, 8'h20, 8'h20, 8'h20});
      vecs.push_back('{8'h0F, 8'h20, 8'h20, 8'h20});
      vecs.push_back('{8'hF7, 8'h20, 8'h20, 8'h20});

      // ---- reset ----
      rst_n          = 1'b0;
      bus.char_xy    = 8'h0B;
      bus.score_in   = '0;
      bus.hiscore_in = '0;
      repeat (3) tick();
      check("reset char_code main", bus.char_code, 8'h20);
      check("reset char_code d4",   bus_d4.char_code, 8'h20);
      check("reset bcd_valid",      bus.bcd_valid, 0);
      rst_n = 1'b1;
      #1;
      check("bcd_valid before first edge", bus.bcd_valid, 0);
      tick();
      check("bcd_valid 1 cycle after release", bus.bcd_valid, 1);

      foreach (vecs[i])
         read_cell(vecs[i].xy, vecs[i].e_main, vecs[i].e_nz, vecs[i].e_d4, "reset_tbl");

      // ---- 1234: exact latency ----
      bus.score_in = 16'd1234;
      bus.char_xy  = 8'h0B;
      for (int i = 0; i <= 18; i++) begin
         tick();
         if (i == 17) begin
            check("1234 lsd at E+17", bus.char_code, 8'h30);
            check("1234 valid at E+17", bus.bcd_valid, 0);
         end
         if (i == 18) begin
            check("1234 lsd at E+18", bus.char_code, 8'h34);
            check("1234 valid at E+18", bus.bcd_valid, 1);
         end
      end
      check_rows(1234, 0, "s1234");

      // ---- saturation and boundaries ----
      bus.score_in = 16'd65535; wait_valid("65535"); check_rows(65535, 0, "s65535");
      bus.score_in = 16'd9999;  wait_valid("9999");  check_rows(9999,  0, "s9999");
      bus.score_in = 16'd10000; wait_valid("10000"); check_rows(10000, 0, "s10000");

      // ---- both channels change together ----
      begin
         bit low_ok;
         low_ok = 1'b1;
         bus.score_in   = 16'd7;
         bus.hiscore_in = 16'd900;
         bus.char_xy    = 8'h0B;
         for (int i = 0; i <= 36; i++) begin
            tick();
            if (i <= 35 && bus.bcd_valid) low_ok = 1'b0;
            if (i == 17) check("both score lsd E+17", bus.char_code, 8'h30);
            if (i == 18) begin
               check("both score lsd E+18", bus.char_code, 8'h37);
               bus.char_xy = 8'h19;
            end
            if (i == 35) check("both hi hundreds E+35", bus.char_code, 8'h20);
            if (i == 36) begin
               check("both hi hundreds E+36", bus.char_code, 8'h39);
               check("both valid at E+36", bus.bcd_valid, 1);
            end
         end
         check("both valid low throughout", low_ok, 1);
      end
      check_rows(7, 900, "s7h900");

      // ---- input change during SHIFT ----
      bus.score_in = 16'd100;
      bus.char_xy  = 8'h0B;
      for (int i = 0; i <= 36; i++) begin
         logic [7:0] e;
         tick();
         if (i == 5) bus.score_in = 16'd101;
         e = (i <= 17) ? 8'h37 : (i <= 35) ? 8'h30 : 8'h31;
         check($sformatf("midshift lsd E+%0d", i), bus.char_code, e);
      end
      check_rows(101, 900, "s101");

      // ---- reset mid-SHIFT ----
      bus.score_in = 16'd5555;
      bus.char_xy  = 8'h0B;
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      check("midreset char_code", bus.char_code, 8'h20);
      check("midreset bcd_valid", bus.bcd_valid, 0);
      bus.score_in   = 16'd42;
      bus.hiscore_in = 16'd0;
      repeat (2) tick();
      check("in reset char_code", bus.char_code, 8'h20);
      rst_n = 1'b1;
      for (int i = 0; i <= 18; i++) begin
         tick();
         if (i == 17) check("after reset lsd E+17", bus.char_code, 8'h30);
         if (i == 18) begin
            check("after reset lsd E+18", bus.char_code, 8'h32);
            check("after reset valid E+18", bus.bcd_valid, 1);
         end
      end
      check_rows(42, 0, "s42");

      // ---- unchanged input: no conversion ----
      bus.score_in = 16'd42;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("steady valid %0d", i), bus.bcd_valid, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
